// File: rtl/ram_access_controller.sv
// ram_access_controller
// Front end for a 32-word single-port RAM. It takes one read or write request
// at a time, range-checks the address, issues a single-cycle RAM strobe, and
// returns read data or a write acknowledgement on a valid/ready response
// channel. It also keeps wrapping read/write counters and a saturating error
// counter.
//
// State table:
//   state   | meaning
//   S_IDLE  | ready for a request (o_req_ready = 1)
//   S_WRITE | write strobe to RAM this cycle
//   S_READ  | read strobe to RAM this cycle; data captured on the next edge
//   S_RESP  | response presented, waiting for i_rsp_ready
//
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_req_valid/o_req_ready              request handshake
//   i_req_write, i_req_addr, i_req_wdata request payload
//   o_rsp_valid/i_rsp_ready              response handshake
//   o_rsp_rdata, o_rsp_err               response payload
//   o_ram_*, i_ram_data_out              RAM port
//   o_wr_count, o_rd_count, o_err_count  debug counters
module ram_access_controller #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [DATA_W-1:0] o_ram_data_in,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic              o_ram_write_enable,
  output logic              o_ram_read_enable,
  input  logic [DATA_W-1:0] i_ram_data_out,
  output logic [15:0]       o_wr_count,
  output logic [15:0]       o_rd_count,
  output logic [7:0]        o_err_count
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_ram_data_in;
  logic [ADDR_W-1:0] r_ram_address;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [15:0]       r_wr_count;
  logic [15:0]       r_rd_count;
  logic [7:0]        r_err_count;
  logic              w_accept;
  logic              w_addr_err;

  assign w_accept   = (r_state == S_IDLE) && i_req_valid;
  assign w_addr_err = (i_req_addr >= ADDR_W'(DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_addr_err)       w_state_nxt = S_RESP;
          else if (i_req_write) w_state_nxt = S_WRITE;
          else                  w_state_nxt = S_READ;
        end
      end
      S_WRITE: w_state_nxt = S_RESP;
      S_READ:  w_state_nxt = S_RESP;
      S_RESP:  if (i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and counters. Address and write data are only reloaded on an
  // in-range accept so the RAM port holds its last values while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_data_in <= '0;
      r_ram_address <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_wr_count    <= '0;
      r_rd_count    <= '0;
      r_err_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_addr_err) begin
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end else begin
              r_ram_address <= i_req_addr;
              if (i_req_write) r_ram_data_in <= i_req_wdata;
            end
          end
        end
        S_WRITE: begin
          r_wr_count  <= r_wr_count + 16'd1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        S_READ: begin
          // RAM drove data_out on the falling edge inside this cycle.
          r_rd_count  <= r_rd_count + 16'd1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= i_ram_data_out;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state register so an async reset drops
  // them immediately and they can never overlap.
  assign o_ram_write_enable = (r_state == S_WRITE);
  assign o_ram_read_enable  = (r_state == S_READ);
  assign o_rsp_valid        = (r_state == S_RESP);
  assign o_req_ready        = (r_state == S_IDLE) && i_rst_n;
  assign o_ram_data_in      = r_ram_data_in;
  assign o_ram_address      = r_ram_address;
  assign o_rsp_rdata        = r_rsp_rdata;
  assign o_rsp_err          = r_rsp_err;
  assign o_wr_count         = r_wr_count;
  assign o_rd_count         = r_rd_count;
  assign o_err_count        = r_err_count;

endmodule

// File: tb/tb_ram_access_controller.sv
module tb_ram_access_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] ram_din;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic        ram_re;
  logic [15:0] ram_dout = '0;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_access_controller #(.DATA_W(16), .ADDR_W(16), .DEPTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_ram_data_in(ram_din), .o_ram_address(ram_addr),
    .o_ram_write_enable(ram_we), .o_ram_read_enable(ram_re),
    .i_ram_data_out(ram_dout),
    .o_wr_count(wr_count), .o_rd_count(rd_count), .o_err_count(err_count)
  );

  // Behavioural RAM attached to the DUT
  logic [15:0] ram_mem [32];
  initial for (int i = 0; i < 32; i++) ram_mem[i] = '0;
  always @(posedge clk) if (ram_we) ram_mem[ram_addr[4:0]] <= ram_din;
  always @(negedge clk) if (ram_re) ram_dout <= ram_mem[ram_addr[4:0]];

  // Reference model
  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] ref_mem [32];
  int          m_wr = 0, m_rd = 0, m_err = 0;
  int          we_cyc = 0, re_cyc = 0;
  int          rsp_mode = 0;  // 0: always ready, 1: random, 2: driven by main

  initial for (int i = 0; i < 32; i++) ref_mem[i] = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response consumer pacing, changed away from both clock edges
  initial forever begin
    @(posedge clk);
    #2;
    if (rsp_mode == 0) rsp_ready = 1'b1;
    else if (rsp_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard pop on handshake, stability during stalls, strobe rules
  logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_err = 1'b0;
  logic [15:0] prev_rdata = '0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (ram_we || ram_re) check("strobe_exclusive", {31'b0, ram_we & ram_re}, 32'd0);
    if (ram_we) we_cyc++;
    if (ram_re) re_cyc++;
    if (rst_n && rsp_valid && prev_valid && !prev_hs) begin
      check("stall_rdata_stable", {16'b0, rsp_rdata}, {16'b0, prev_rdata});
      check("stall_err_stable", {31'b0, rsp_err}, {31'b0, prev_err});
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, e.rdata});
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
    prev_valid = rsp_valid;
    prev_hs    = rsp_ready;
    prev_rdata = rsp_rdata;
    prev_err   = rsp_err;
  end

  // Issue one request; returns 1 time unit after the accepting rising edge.
  task automatic do_req(input bit w, input logic [15:0] a, input logic [15:0] d, input int gap);
    bit   rdy;
    int   n;
    exp_t e;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    forever begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 300) break;
      @(negedge clk);
    end
    if (!rdy) begin
      check("req_accept_timeout", 32'd0, 32'd1);
    end else begin
      if (a >= 16'd32) begin
        e.err = 1'b1; e.rdata = '0;
        if (m_err < 255) m_err++;
      end else if (w) begin
        ref_mem[a[4:0]] = d;
        e.err = 1'b0; e.rdata = '0;
        m_wr++;
      end else begin
        e.err = 1'b0; e.rdata = ref_mem[a[4:0]];
        m_rd++;
      end
      exp_q.push_back(e);
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_wr_count"}, {16'b0, wr_count}, 32'(m_wr & 16'hFFFF));
    check({tag, "_rd_count"}, {16'b0, rd_count}, 32'(m_rd & 16'hFFFF));
    check({tag, "_err_count"}, {24'b0, err_count}, 32'(m_err));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] saved;
    // Reset state
    #3;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_strobes", {30'b0, ram_we, ram_re}, 32'd0);
    check("rst_ram_addr", {16'b0, ram_addr}, 32'd0);
    check("rst_ram_din", {16'b0, ram_din}, 32'd0);
    check("rst_rsp_rdata", {15'b0, rsp_err, rsp_rdata}, 32'd0);
    check_counts("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Write addr 5
    do_req(1'b1, 16'd5, 16'hA5A5, 0);
    check("wr_strobe", {30'b0, ram_we, ram_re}, 32'd2);
    check("wr_ram_addr", {16'b0, ram_addr}, 32'd5);
    check("wr_ram_din", {16'b0, ram_din}, 32'hA5A5);
    check("wr_no_rsp_yet", {30'b0, rsp_valid, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("wr_strobe_drop", {30'b0, ram_we, ram_re}, 32'd0);
    check("wr_rsp", {14'b0, rsp_valid, rsp_err, rsp_rdata}, 32'h2_0000);
    check("wr_count_1", {16'b0, wr_count}, 32'd1);
    wait_idle();

    // Read addr 5
    do_req(1'b0, 16'd5, 16'h0, 0);
    check("rd_strobe", {30'b0, ram_we, ram_re}, 32'd1);
    check("rd_ram_addr", {16'b0, ram_addr}, 32'd5);
    check("rd_no_rsp_yet", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("rd_rsp", {14'b0, rsp_valid, rsp_err, rsp_rdata}, 32'h2_A5A5);
    check("rd_count_1", {16'b0, rd_count}, 32'd1);
    wait_idle();

    // Out-of-range requests
    do_req(1'b0, 16'd32, 16'h0, 0);
    check("err_rd_rsp", {14'b0, rsp_valid, rsp_err, rsp_rdata}, 32'h3_0000);
    check("err_rd_strobe", {30'b0, ram_we, ram_re}, 32'd0);
    wait_idle();
    do_req(1'b1, 16'hFFFF, 16'h5555, 0);
    check("err_wr_rsp", {14'b0, rsp_valid, rsp_err, rsp_rdata}, 32'h3_0000);
    check("err_wr_strobe", {30'b0, ram_we, ram_re}, 32'd0);
    wait_idle();
    check_counts("err2");
    check("err2_err_count_2", {24'b0, err_count}, 32'd2);
    for (int i = 0; i < 300; i++)
      do_req(1'($urandom_range(0, 1)), 16'($urandom_range(32, 65535)), 16'($urandom), 0);
    wait_idle();
    check_counts("err_sat");
    check("err_sat_255", {24'b0, err_count}, 32'd255);
    check("err_no_extra_we", 32'(we_cyc), 32'd1);
    check("err_no_extra_re", 32'(re_cyc), 32'd1);

    // Stalled response on read of addr 31
    do_req(1'b1, 16'd31, 16'h1234, 0);
    wait_idle();
    rsp_mode = 2;
    rsp_ready = 1'b0;
    do_req(1'b0, 16'd31, 16'h0, 0);
    repeat (11) begin
      @(posedge clk); #1;
      check("stall_rsp", {14'b0, rsp_valid, rsp_err, rsp_rdata}, 32'h2_1234);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
      check("stall_rd_count", {16'b0, rd_count}, 32'(m_rd));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_idle", {30'b0, req_ready, rsp_valid}, 32'd2);
    rsp_mode = 0;
    wait_idle();

    // Reset while the write strobe is high
    saved = ref_mem[7];
    do_req(1'b1, 16'd7, 16'hBEEF, 0);
    check("rstmid_we_high", {31'b0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    ref_mem[7] = saved;
    m_wr = 0; m_rd = 0; m_err = 0;
    check("rstmid_strobe", {30'b0, ram_we, ram_re}, 32'd0);
    check("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_counts("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    we_cyc = 0; re_cyc = 0;
    repeat (4) @(negedge clk);
    check("rstmid_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Full sweep with random gaps and random response back-pressure
    rsp_mode = 1;
    for (int i = 0; i < 32; i++) do_req(1'b1, 16'(i), 16'(~i), $urandom_range(0, 3));
    for (int i = 0; i < 32; i++) do_req(1'b0, 16'(i), 16'h0, $urandom_range(0, 3));
    rsp_mode = 0;
    wait_idle();
    check_counts("sweep");
    check("sweep_wr_32", {16'b0, wr_count}, 32'd32);
    check("sweep_rd_32", {16'b0, rd_count}, 32'd32);
    check("sweep_we_cycles", 32'(we_cyc), 32'd32);
    check("sweep_re_cycles", 32'(re_cyc), 32'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
